// File: rtl/lsu_wb_align.sv
// LSU writeback: waits for the load response, aligns and extends it, and writes the register file.
// Define LSU_WB_TIMEOUT_EN to abort a load whose response takes TIMEOUT_CYCLES S_WAIT cycles.
module lsu_wb_align #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            is_load_in,
  input  logic            zero_ext_in,
  input  logic            is_nop_in,
  input  logic [1:0]      size_in,
  input  logic [4:0]      rd_in,
  input  logic [1:0]      addr_lo_in,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall_out,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e          state_q;
  logic            stall_q;
  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            zext_q;
  logic [1:0]      size_q;
  logic [4:0]      rd_q;
  logic [1:0]      addr_lo_q;
  logic            accept_s;
  logic [XLEN-1:0] wdata_d;

`ifdef LSU_WB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_err_q;
`endif

  // Halves ignore addr_lo[0]: misaligned halfword loads are not supported.
  function automatic logic [XLEN-1:0] align_extend(
    input logic [XLEN-1:0] data,
    input logic [1:0]      size,
    input logic [1:0]      off,
    input logic            zext
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = off[1] ? data[31:16] : data[15:0];
    case (size)
      2'b00:   r = {{(XLEN-8){b[7] & ~zext}}, b};
      2'b01:   r = {{(XLEN-16){h[15] & ~zext}}, h};
      default: r = data;
    endcase
    return r;
  endfunction

  // Load acceptance and the aligned response for the captured load.
  always_comb begin
    accept_s = is_load_in & ~is_nop_in;
    wdata_d  = align_extend(mem_rdata, size_q, addr_lo_q, zext_q);
  end

  // Writeback FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      zext_q     <= 1'b0;
      size_q     <= 2'b00;
      rd_q       <= 5'd0;
      addr_lo_q  <= 2'b00;
`ifdef LSU_WB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      rf_we_q <= 1'b0;
`ifdef LSU_WB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE, S_WRITE: begin
          if (accept_s) begin
            state_q   <= S_WAIT;
            stall_q   <= 1'b1;
            zext_q    <= zero_ext_in;
            size_q    <= size_in;
            rd_q      <= rd_in;
            addr_lo_q <= addr_lo_in;
`ifdef LSU_WB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end else begin
            state_q <= S_IDLE;
            stall_q <= 1'b0;
          end
        end
        S_WAIT: begin
          // A response in the expiry cycle still wins over the timeout.
          if (mem_rvalid) begin
            state_q    <= S_WRITE;
            stall_q    <= 1'b0;
            rf_we_q    <= (rd_q != 5'd0);
            rf_waddr_q <= rd_q;
            rf_wdata_q <= wdata_d;
          end
`ifdef LSU_WB_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_q       <= S_IDLE;
            stall_q       <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`else
          else begin
            stall_q <= 1'b1;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall_out = stall_q;
  assign busy      = stall_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
`ifdef LSU_WB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_wb_align.sv
// Self-checking bench for lsu_wb_align: directed load scenarios with literal expectations,
// then randomized traffic, all checked every cycle against an outstanding-load reference model.
module tb_lsu_wb_align;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_load_in;
  logic        zero_ext_in;
  logic        is_nop_in;
  logic [1:0]  size_in;
  logic [4:0]  rd_in;
  logic [1:0]  addr_lo_in;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_out;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        timeout_err;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_wb_align #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .is_load_in  (is_load_in),
    .zero_ext_in (zero_ext_in),
    .is_nop_in   (is_nop_in),
    .size_in     (size_in),
    .rd_in       (rd_in),
    .addr_lo_in  (addr_lo_in),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .stall_out   (stall_out),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load result: pick the naturally aligned lane, then extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] sz,
                                           input logic [1:0] off, input logic zx);
    int unsigned nbytes, lane, lim, v;
    nbytes = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    if (nbytes == 4) return d;
    lane = (nbytes == 2) ? (32'(off) / 2) * 2 : 32'(off);
    lim  = 32'd1 << (8 * nbytes);
    v    = (d >> (8 * lane)) % lim;
    if (!zx && v >= lim / 2) v = v - lim;
    return v;
  endfunction

  // Model state: whether a load is outstanding, what it asked for, and the expected outputs.
  bit          m_pend = 1'b0;
  logic        m_zx;
  logic [1:0]  m_sz;
  logic [1:0]  m_off;
  logic [4:0]  m_rd;
  int          m_cnt;
  bit          e_we;
  bit          e_stall;
  bit          e_terr;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_pend  = 1'b0;
      e_we    = 1'b0;
      e_stall = 1'b0;
      e_terr  = 1'b0;
      e_waddr = 5'd0;
      e_wdata = 32'd0;
    end else begin
      e_we   = 1'b0;
      e_terr = 1'b0;
      if (m_pend) begin
        if (mem_rvalid) begin
          m_pend  = 1'b0;
          e_we    = (m_rd != 5'd0);
          e_waddr = m_rd;
          e_wdata = ref_load(mem_rdata, m_sz, m_off, m_zx);
        end
`ifdef LSU_WB_TIMEOUT_EN
        else if (m_cnt == TO - 1) begin
          m_pend = 1'b0;
          e_terr = 1'b1;
        end
`endif
        else begin
          m_cnt++;
        end
      end else if (is_load_in && !is_nop_in) begin
        m_pend = 1'b1;
        m_zx   = zero_ext_in;
        m_sz   = size_in;
        m_off  = addr_lo_in;
        m_rd   = rd_in;
        m_cnt  = 0;
      end
      e_stall = m_pend;
    end
    #1;
    chk("rf_we", rf_we, e_we);
    chk("stall_out", stall_out, e_stall);
    chk("busy", busy, e_stall);
    chk("rf_waddr", rf_waddr, e_waddr);
    chk("rf_wdata", rf_wdata, e_wdata);
    chk("timeout_err", timeout_err, e_terr);
  end

  task automatic drv(input logic ld, input logic nop, input logic zx, input logic [1:0] sz,
                     input logic [4:0] rd, input logic [1:0] off, input logic rv,
                     input logic [31:0] dat);
    @(negedge clk);
    is_load_in  = ld;
    is_nop_in   = nop;
    zero_ext_in = zx;
    size_in     = sz;
    rd_in       = rd;
    addr_lo_in  = off;
    mem_rvalid  = rv;
    mem_rdata   = dat;
  endtask

  task automatic idle(input logic rv, input logic [31:0] dat);
    drv(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'd0, rv, dat);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst         = 1'b1;
    is_load_in  = 1'b0;
    is_nop_in   = 1'b0;
    zero_ext_in = 1'b0;
    size_in     = 2'b00;
    rd_in       = 5'd0;
    addr_lo_in  = 2'd0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'd0;
    repeat (2) settle();
    chk("reset_we", rf_we, 32'd0);
    chk("reset_stall", stall_out, 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // LB, sign-extended, offset 1
    drv(1'b1, 1'b0, 1'b0, 2'b00, 5'd5, 2'd1, 1'b0, 32'd0);
    idle(1'b1, 32'h123480FF);
    settle();
    chk("lb_we", rf_we, 32'd1);
    chk("lb_wdata", rf_wdata, 32'hFFFFFF80);

    // LHU, offset 2
    drv(1'b1, 1'b0, 1'b1, 2'b01, 5'd7, 2'd2, 1'b0, 32'd0);
    idle(1'b1, 32'h8001BEEF);
    settle();
    chk("lhu_waddr", rf_waddr, 32'd7);
    chk("lhu_wdata", rf_wdata, 32'h00008001);

    // LW with a response three cycles after acceptance
    drv(1'b1, 1'b0, 1'b0, 2'b10, 5'd9, 2'd3, 1'b0, 32'd0);
    settle();
    chk("lw_stall_1", stall_out, 32'd1);
    idle(1'b0, 32'd0);
    settle();
    chk("lw_stall_2", stall_out, 32'd1);
    idle(1'b0, 32'd0);
    settle();
    chk("lw_stall_3", stall_out, 32'd1);
    idle(1'b1, 32'hDEADBEEF);
    settle();
    chk("lw_stall_end", stall_out, 32'd0);
    chk("lw_we", rf_we, 32'd1);
    chk("lw_wdata", rf_wdata, 32'hDEADBEEF);
    idle(1'b0, 32'd0);
    settle();
    chk("lw_we_pulse", rf_we, 32'd0);
    chk("lw_wdata_hold", rf_wdata, 32'hDEADBEEF);

    // rd=0 load, then a store and a NOP with stray responses
    drv(1'b1, 1'b0, 1'b0, 2'b10, 5'd0, 2'd0, 1'b0, 32'd0);
    idle(1'b1, 32'hCAFEF00D);
    settle();
    chk("rd0_we", rf_we, 32'd0);
    drv(1'b0, 1'b0, 1'b0, 2'b10, 5'd4, 2'd0, 1'b1, 32'h01010101);
    settle();
    chk("store_we", rf_we, 32'd0);
    chk("store_stall", stall_out, 32'd0);
    drv(1'b1, 1'b1, 1'b0, 2'b10, 5'd4, 2'd0, 1'b1, 32'h02020202);
    settle();
    chk("nop_we", rf_we, 32'd0);
    chk("nop_stall", stall_out, 32'd0);

    // Back-to-back LW then LB accepted in the write cycle
    drv(1'b1, 1'b0, 1'b0, 2'b10, 5'd3, 2'd0, 1'b0, 32'd0);
    idle(1'b1, 32'h11223344);
    settle();
    chk("b2b_lw_wdata", rf_wdata, 32'h11223344);
    drv(1'b1, 1'b0, 1'b0, 2'b00, 5'd4, 2'd3, 1'b0, 32'd0);
    settle();
    chk("b2b_accept_stall", stall_out, 32'd1);
    idle(1'b1, 32'hA5000000);
    settle();
    chk("b2b_lb_waddr", rf_waddr, 32'd4);
    chk("b2b_lb_wdata", rf_wdata, 32'hFFFFFFA5);

    // Reset while waiting; the late response must be ignored
    drv(1'b1, 1'b0, 1'b0, 2'b10, 5'd6, 2'd0, 1'b0, 32'd0);
    idle(1'b0, 32'd0);
    settle();
    @(negedge clk);
    rst = 1'b1;
    settle();
    chk("rst_stall", stall_out, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55AA55AA;
    settle();
    chk("late_rvalid_we", rf_we, 32'd0);
    chk("late_rvalid_stall", stall_out, 32'd0);
    idle(1'b0, 32'd0);

`ifdef LSU_WB_TIMEOUT_EN
    // Timeout after four waiting cycles, then a response in the expiry cycle
    drv(1'b1, 1'b0, 1'b0, 2'b10, 5'd8, 2'd0, 1'b0, 32'd0);
    repeat (4) idle(1'b0, 32'd0);
    settle();
    chk("to_err", timeout_err, 32'd1);
    chk("to_we", rf_we, 32'd0);
    idle(1'b0, 32'd0);
    settle();
    chk("to_err_pulse", timeout_err, 32'd0);
    drv(1'b1, 1'b0, 1'b0, 2'b10, 5'd8, 2'd0, 1'b0, 32'd0);
    repeat (3) idle(1'b0, 32'd0);
    idle(1'b1, 32'h0BADF00D);
    settle();
    chk("to_race_we", rf_we, 32'd1);
    chk("to_race_err", timeout_err, 32'd0);
    chk("to_race_wdata", rf_wdata, 32'h0BADF00D);
`endif

    // Randomized traffic, including stray responses and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 99) == 0);
      is_load_in  = ($urandom_range(0, 99) < 40);
      is_nop_in   = ($urandom_range(0, 3) == 0);
      zero_ext_in = 1'($urandom_range(0, 1));
      size_in     = 2'($urandom_range(0, 3));
      rd_in       = 5'($urandom_range(0, 31));
      addr_lo_in  = 2'($urandom_range(0, 3));
      mem_rvalid  = ($urandom_range(0, 99) < 35);
      mem_rdata   = $urandom;
    end
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0, 32'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
